light_decrypt_arbiter: RTL

- Shares one light decryptor instance between NUM_CH independent requester channels using round-robin arbitration.
- Accepts one 640-bit ciphertext from the winning channel and latches it. Drives the latched value to the decryptor, which reads its ciphertext input combinationally until its response is consumed.
- Routes the plaintext and HMAC back to the granted channel.
- Sits between the CL-side stream channels and the decryptor. Exactly one transaction is in flight at a time.

---
 rtl/light_pkg.sv | 14 +
 rtl/light_rr_arbiter.sv | 38 +++
 rtl/light_decrypt_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/light_pkg.sv
// Shared definitions for the LIGHT decryptor front-end: datapath widths and
// the arbiter FSM encoding.
package light_pkg;

  localparam int LIGHT_CT_WIDTH   = 640;
  localparam int LIGHT_HMAC_WIDTH = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } light_arb_state_t;

endpackage

// File: rtl/light_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr_i,
// wrapping modulo NUM_CH. Shared by the crypto engine front-ends.
module light_rr_arbiter #(
  parameter int  NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   rr_ptr_i,
  output logic [NUM_CH-1:0] gnt_oh_o,
  output logic [CH_W-1:0]   gnt_idx_o,
  output logic              any_gnt_o
);

  int              pos;
  logic [CH_W-1:0] cand;
  logic            found;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    pos       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      // explicit wrap keeps non-power-of-two channel counts correct
      pos = int'(rr_ptr_i) + k;
      if (pos >= NUM_CH) pos = pos - NUM_CH;
      cand = CH_W'(pos);
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        gnt_idx_o       = cand;
        gnt_oh_o[cand]  = 1'b1;
      end
    end
    any_gnt_o = found;
  end

endmodule

// File: rtl/light_decrypt_arbiter.sv
// Round-robin front-end sharing one LIGHT decryptor across NUM_CH requesters;
// one transaction in flight, ciphertext latched, response routed to the owner.
module light_decrypt_arbiter
  import light_pkg::*;
#(
  parameter int  NUM_CH   = 4,
  parameter int  CT_WIDTH = LIGHT_CT_WIDTH,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH*CT_WIDTH-1:0]    ch_req_ciphertext,
  input  logic [NUM_CH-1:0]             ch_req_val,
  output logic [NUM_CH-1:0]             ch_req_rdy,
  output logic [CT_WIDTH-1:0]           ch_resp_plaintext,
  output logic [LIGHT_HMAC_WIDTH-1:0]   ch_resp_hmac,
  output logic [NUM_CH-1:0]             ch_resp_val,
  input  logic [NUM_CH-1:0]             ch_resp_rdy,
  output logic [CT_WIDTH-1:0]           dec_req_ciphertext,
  output logic                          dec_req_val,
  input  logic                          dec_req_rdy,
  input  logic [CT_WIDTH-1:0]           dec_resp_plaintext,
  input  logic [LIGHT_HMAC_WIDTH-1:0]   dec_resp_hmac,
  input  logic                          dec_resp_val,
  output logic                          dec_resp_rdy,
  output logic                          busy,
  output logic [CH_W-1:0]               grant_id
);

  light_arb_state_t                  state_q, state_d;
  logic [CH_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]                   grant_q, grant_d;
  logic [CT_WIDTH-1:0]               ct_q, ct_d;
  logic                              ct_en;

  logic [NUM_CH-1:0][CT_WIDTH-1:0]   ch_ct;
  logic [NUM_CH-1:0]                 gnt_oh;
  logic [CH_W-1:0]                   gnt_idx;
  logic                              any_gnt;

  assign ch_ct = ch_req_ciphertext;

  light_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req_i     (ch_req_val),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .any_gnt_o (any_gnt)
  );

  assign ct_d = ch_ct[gnt_idx];

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    ct_en        = 1'b0;
    ch_req_rdy   = '0;
    ch_resp_val  = '0;
    dec_req_val  = 1'b0;
    dec_resp_rdy = 1'b0;
    unique case (state_q)
      IDLE: begin
        ch_req_rdy = gnt_oh;
        if (any_gnt) begin
          ct_en   = 1'b1;
          grant_d = gnt_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        dec_req_val = 1'b1;
        if (dec_req_rdy) state_d = WAIT;
      end
      WAIT: begin
        // only the owner's ready reaches the decryptor; others are ignored
        ch_resp_val[grant_q] = dec_resp_val;
        dec_resp_rdy         = ch_resp_rdy[grant_q];
        if (dec_resp_val && ch_resp_rdy[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + CH_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        ct_q <= '0;
    else if (ct_en) ct_q <= ct_d;
  end

  assign dec_req_ciphertext = ct_q;
  assign ch_resp_plaintext  = dec_resp_plaintext;
  assign ch_resp_hmac       = dec_resp_hmac;
  assign busy               = (state_q != IDLE);
  assign grant_id           = busy ? grant_q : '0;

  a_req_rdy_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(ch_req_rdy));
  a_resp_val_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(ch_resp_val));

endmodule
